// File: rtl/risc_controller_pkg.sv
// Shared types for the Simple RISC Machine controller: IR field layout,
// FSM state encoding, decoded instruction kinds and register-index selects.
// No logic latency; pure declarations plus one combinational decode helper.
package risc_controller_pkg;

    // Instruction word layout. imm8 overlays {rd, sh, rm}; imm5 overlays {sh, rm}.
    typedef struct packed {
        logic [2:0] opcode;
        logic [1:0] op;
        logic [2:0] rn;
        logic [2:0] rd;
        logic [1:0] sh;
        logic [2:0] rm;
    } ir_t;

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_GET_A,
        S_GET_B,
        S_COMPUTE,
        S_WRITE_REG,
        S_WRITE_IMM
    } state_e;

    typedef enum logic [2:0] {
        I_MOV_IMM,
        I_MOV_REG,
        I_ADD,
        I_CMP,
        I_AND,
        I_MVN,
        I_ILLEGAL
    } instr_e;

    // Which IR register field drives a register-file index.
    typedef enum logic [1:0] {
        NSEL_NONE,
        NSEL_RN,
        NSEL_RD,
        NSEL_RM
    } nsel_e;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;

    localparam logic [3:0] VSEL_IMM8 = 4'b0100;
    localparam logic [3:0] VSEL_C    = 4'b0001;

    function automatic instr_e decode_instr(input logic [2:0] opcode, input logic [1:0] op);
        instr_e kind;
        kind = I_ILLEGAL;
        if (opcode == OPC_MOV) begin
            if (op == 2'b10)      kind = I_MOV_IMM;
            else if (op == 2'b00) kind = I_MOV_REG;
        end else if (opcode == OPC_ALU) begin
            case (op)
                2'b00:   kind = I_ADD;
                2'b01:   kind = I_CMP;
                2'b10:   kind = I_AND;
                default: kind = I_MVN;
            endcase
        end
        return kind;
    endfunction

endpackage

// File: rtl/risc_controller_if.sv
// Bundle between the top level (switches/keys) and the datapath control inputs.
// master: the controller (consumes instruction/start, drives controls and immediates).
// slave: the surrounding top level / datapath view of the same wires.
interface risc_controller_if;
    logic [15:0] in;
    logic        load_ir;
    logic        s;
    logic        w;
    logic        illegal;
    logic [3:0]  vsel;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic [1:0]  shift;
    logic [1:0]  ALUop;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic [15:0] sximm5;
    logic [15:0] sximm8;

    modport master (
        input  in, load_ir, s,
        output w, illegal, vsel, loada, loadb, loadc, loads, asel, bsel,
               shift, ALUop, readnum, writenum, write, sximm5, sximm8
    );

    modport slave (
        output in, load_ir, s,
        input  w, illegal, vsel, loada, loadb, loadc, loads, asel, bsel,
               shift, ALUop, readnum, writenum, write, sximm5, sximm8
    );
endinterface

// File: rtl/risc_controller_instr_dec.sv
// Instruction decoder: splits IR fields, sign-extends immediates, muxes register indices.
// Latency: purely combinational. Backpressure: none (no handshake).
// Ports: ir in; rsel/wsel pick the IR field for readnum/writenum; kind/op/sh/sximm* out.
module risc_controller_instr_dec
    import risc_controller_pkg::*;
(
    input  ir_t         ir,
    input  nsel_e       rsel,
    input  nsel_e       wsel,
    output instr_e      kind,
    output logic [1:0]  op,
    output logic [1:0]  sh,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic [15:0] sximm5,
    output logic [15:0] sximm8
);

    function automatic logic [2:0] pick(input nsel_e sel, input ir_t w);
        case (sel)
            NSEL_RN: return w.rn;
            NSEL_RD: return w.rd;
            NSEL_RM: return w.rm;
            default: return 3'b000;
        endcase
    endfunction

    assign kind     = decode_instr(ir.opcode, ir.op);
    assign op       = ir.op;
    assign sh       = ir.sh;
    assign readnum  = pick(rsel, ir);
    assign writenum = pick(wsel, ir);
    assign sximm8   = {{8{ir.rd[2]}}, ir.rd, ir.sh, ir.rm};
    assign sximm5   = {{11{ir.sh[1]}}, ir.sh, ir.rm};

endmodule

// File: rtl/risc_controller.sv
// Control FSM + instruction register for the Simple RISC Machine datapath.
// Latency s->w: MOV imm 3, MOV reg/MVN/CMP 5, ADD/AND 6 cycles; outputs are Moore.
// Backpressure: load_ir and s are only accepted while w=1; ignored otherwise.
// Ports: clk, reset_n (sync, active-low), bus (master modport: in/load_ir/s in,
//        datapath controls, w, illegal and sximm5/sximm8 out).
module risc_controller
    import risc_controller_pkg::*;
(
    input logic              clk,
    input logic              reset_n,
    risc_controller_if.master bus
);

    state_e state;
    state_e state_nxt;
    ir_t    ir;
    instr_e kind;
    logic [1:0] op;
    logic [1:0] sh;
    nsel_e  rsel;
    nsel_e  wsel;

    risc_controller_instr_dec u_dec (
        .ir       (ir),
        .rsel     (rsel),
        .wsel     (wsel),
        .kind     (kind),
        .op       (op),
        .sh       (sh),
        .readnum  (bus.readnum),
        .writenum (bus.writenum),
        .sximm5   (bus.sximm5),
        .sximm8   (bus.sximm8)
    );

    // IR load and the start decision share the WAIT edge, so a simultaneous
    // load_ir + s decodes the freshly loaded word.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_WAIT;
            ir    <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_WAIT && bus.load_ir) begin
                ir <= ir_t'(bus.in);
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        rsel        = NSEL_NONE;
        wsel        = NSEL_NONE;
        bus.w       = 1'b0;
        bus.illegal = 1'b0;
        bus.vsel    = VSEL_C;
        bus.loada   = 1'b0;
        bus.loadb   = 1'b0;
        bus.loadc   = 1'b0;
        bus.loads   = 1'b0;
        bus.asel    = 1'b0;
        bus.bsel    = 1'b0;
        bus.shift   = 2'b00;
        bus.ALUop   = ALU_ADD;
        bus.write   = 1'b0;

        case (state)
            S_WAIT: begin
                bus.w = 1'b1;
                if (bus.s) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                case (kind)
                    I_MOV_IMM:               state_nxt = S_WRITE_IMM;
                    I_MOV_REG, I_MVN:        state_nxt = S_GET_B;
                    I_ADD, I_CMP, I_AND:     state_nxt = S_GET_A;
                    default: begin
                        bus.illegal = 1'b1;
                        state_nxt   = S_WAIT;
                    end
                endcase
            end
            S_GET_A: begin
                rsel      = NSEL_RN;
                bus.loada = 1'b1;
                state_nxt = S_GET_B;
            end
            S_GET_B: begin
                rsel      = NSEL_RM;
                bus.loadb = 1'b1;
                state_nxt = S_COMPUTE;
            end
            S_COMPUTE: begin
                bus.shift = sh;
                case (kind)
                    I_MOV_REG: begin
                        // A forced to zero so the ALU passes the shifted Rm through.
                        bus.asel  = 1'b1;
                        bus.ALUop = ALU_ADD;
                        bus.loadc = 1'b1;
                        state_nxt = S_WRITE_REG;
                    end
                    I_CMP: begin
                        // Subtract only to update status; the result is discarded.
                        bus.ALUop = ALU_SUB;
                        bus.loads = 1'b1;
                        state_nxt = S_WAIT;
                    end
                    default: begin
                        bus.ALUop = op;
                        bus.loadc = 1'b1;
                        state_nxt = S_WRITE_REG;
                    end
                endcase
            end
            S_WRITE_REG: begin
                wsel      = NSEL_RD;
                bus.vsel  = VSEL_C;
                bus.write = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WRITE_IMM: begin
                wsel      = NSEL_RN;
                bus.vsel  = VSEL_IMM8;
                bus.write = 1'b1;
                state_nxt = S_WAIT;
            end
            default: state_nxt = S_WAIT;
        endcase
    end

endmodule

// File: tb/tb_risc_controller.sv
// Bench for risc_controller: per-cycle expected control words are queued when an
// instruction is issued and popped/compared one per clock as the FSM steps.
module tb_risc_controller;

    typedef struct packed {
        logic       w;
        logic       illegal;
        logic [3:0] vsel;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic [1:0] shift;
        logic [1:0] alu;
        logic [2:0] rn;
        logic [2:0] wn;
        logic       write;
    } obs_t;

    logic clk = 1'b0;
    logic reset_n;
    int   vectors = 0;
    int   miscompares = 0;
    obs_t sb[$];
    obs_t got;
    obs_t e;

    risc_controller_if bus();

    risc_controller dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Expected control word for each FSM state, written from the state table.
    function automatic obs_t f_idle();
        obs_t o = '0;
        o.w = 1'b1; o.vsel = 4'b0001;
        return o;
    endfunction
    function automatic obs_t f_dec(input logic ill);
        obs_t o = '0;
        o.vsel = 4'b0001; o.illegal = ill;
        return o;
    endfunction
    function automatic obs_t f_geta(input logic [2:0] rn);
        obs_t o = '0;
        o.vsel = 4'b0001; o.loada = 1'b1; o.rn = rn;
        return o;
    endfunction
    function automatic obs_t f_getb(input logic [2:0] rn);
        obs_t o = '0;
        o.vsel = 4'b0001; o.loadb = 1'b1; o.rn = rn;
        return o;
    endfunction
    function automatic obs_t f_comp(input logic asel, input logic [1:0] sh,
                                    input logic [1:0] alu, input logic lc, input logic ls);
        obs_t o = '0;
        o.vsel = 4'b0001; o.asel = asel; o.shift = sh; o.alu = alu;
        o.loadc = lc; o.loads = ls;
        return o;
    endfunction
    function automatic obs_t f_wreg(input logic [2:0] wn);
        obs_t o = '0;
        o.vsel = 4'b0001; o.wn = wn; o.write = 1'b1;
        return o;
    endfunction
    function automatic obs_t f_wimm(input logic [2:0] wn);
        obs_t o = '0;
        o.vsel = 4'b0100; o.wn = wn; o.write = 1'b1;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.w = bus.w; o.illegal = bus.illegal; o.vsel = bus.vsel;
        o.loada = bus.loada; o.loadb = bus.loadb; o.loadc = bus.loadc; o.loads = bus.loads;
        o.asel = bus.asel; o.bsel = bus.bsel; o.shift = bus.shift; o.alu = bus.ALUop;
        o.rn = bus.readnum; o.wn = bus.writenum; o.write = bus.write;
        return o;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] word);
        bus.in = word;
        bus.load_ir = 1'b1;
        bus.s = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.in = 16'hFFFF; bus.load_ir = 1'b1; bus.s = 1'b1;
        step(); step();
        got = sample(); e = f_idle(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL reset_ctrl: got %h want %h", got, e); end
        vectors++;
        if (bus.sximm8 !== 16'h0000 || bus.sximm5 !== 16'h0000) begin
            miscompares++; $display("FAIL reset_ir: got sximm8=%h sximm5=%h want 0000", bus.sximm8, bus.sximm5);
        end
        bus.load_ir = 1'b0; bus.s = 1'b0;
        reset_n = 1'b1;
        step();
        got = sample(); e = f_idle(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL reset_release: got %h want %h", got, e); end
    endtask

    task automatic test_mov_imm();
        // MOV R1,#5 : DECODE, WRITE_IMM, back in WAIT on the third cycle.
        issue(16'hD105);
        sb.push_back(f_dec(0)); sb.push_back(f_wimm(3'd1)); sb.push_back(f_idle());
        for (int i = 0; sb.size() > 0; i++) begin
            step(); bus.load_ir = 1'b0; bus.s = 1'b0;
            got = sample(); e = sb.pop_front(); vectors++;
            if (got !== e) begin miscompares++; $display("FAIL mov_imm[%0d]: got %h want %h", i, got, e); end
        end
        vectors++;
        if (bus.sximm8 !== 16'h0005) begin miscompares++; $display("FAIL mov_imm_sximm8: got %h want 0005", bus.sximm8); end
        // MOV R0,#-1 straight after: negative imm8 writes R0.
        issue(16'hD0FF);
        sb.push_back(f_dec(0)); sb.push_back(f_wimm(3'd0)); sb.push_back(f_idle());
        for (int i = 0; sb.size() > 0; i++) begin
            step(); bus.load_ir = 1'b0; bus.s = 1'b0;
            got = sample(); e = sb.pop_front(); vectors++;
            if (got !== e) begin miscompares++; $display("FAIL mov_neg[%0d]: got %h want %h", i, got, e); end
        end
        vectors++;
        if (bus.sximm8 !== 16'hFFFF || bus.sximm5 !== 16'hFFFF) begin
            miscompares++; $display("FAIL mov_neg_sx: got sximm8=%h sximm5=%h want FFFF FFFF", bus.sximm8, bus.sximm5);
        end
    endtask

    task automatic test_sximm();
        // load_ir without s: IR updates, FSM stays in WAIT.
        bus.in = 16'h0010; bus.load_ir = 1'b1; bus.s = 1'b0;
        sb.push_back(f_idle());
        step(); bus.load_ir = 1'b0;
        got = sample(); e = sb.pop_front(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL load_only: got %h want %h", got, e); end
        vectors++;
        if (bus.sximm5 !== 16'hFFF0 || bus.sximm8 !== 16'h0010) begin
            miscompares++; $display("FAIL sximm5_neg: got sximm5=%h sximm8=%h want FFF0 0010", bus.sximm5, bus.sximm8);
        end
    endtask

    task automatic test_alu();
        // ADD R5,R0,R1,LSL#1 ; AND R4,R2,R3 ; MVN R6,R5,sh=11 back to back.
        issue(16'hA0A9);
        sb.push_back(f_dec(0)); sb.push_back(f_geta(3'd0)); sb.push_back(f_getb(3'd1));
        sb.push_back(f_comp(0, 2'b01, 2'b00, 1, 0)); sb.push_back(f_wreg(3'd5)); sb.push_back(f_idle());
        for (int i = 0; sb.size() > 0; i++) begin
            step(); bus.load_ir = 1'b0; bus.s = 1'b0;
            got = sample(); e = sb.pop_front(); vectors++;
            if (got !== e) begin miscompares++; $display("FAIL add[%0d]: got %h want %h", i, got, e); end
        end
        issue(16'hB283);
        sb.push_back(f_dec(0)); sb.push_back(f_geta(3'd2)); sb.push_back(f_getb(3'd3));
        sb.push_back(f_comp(0, 2'b00, 2'b10, 1, 0)); sb.push_back(f_wreg(3'd4)); sb.push_back(f_idle());
        for (int i = 0; sb.size() > 0; i++) begin
            step(); bus.load_ir = 1'b0; bus.s = 1'b0;
            got = sample(); e = sb.pop_front(); vectors++;
            if (got !== e) begin miscompares++; $display("FAIL and[%0d]: got %h want %h", i, got, e); end
        end
        issue(16'hB8DD);
        sb.push_back(f_dec(0)); sb.push_back(f_getb(3'd5));
        sb.push_back(f_comp(0, 2'b11, 2'b11, 1, 0)); sb.push_back(f_wreg(3'd6)); sb.push_back(f_idle());
        for (int i = 0; sb.size() > 0; i++) begin
            step(); bus.load_ir = 1'b0; bus.s = 1'b0;
            got = sample(); e = sb.pop_front(); vectors++;
            if (got !== e) begin miscompares++; $display("FAIL mvn[%0d]: got %h want %h", i, got, e); end
        end
    endtask

    task automatic test_mov_reg();
        // MOV R3,R7,sh=10 : A forced to zero, ALU add.
        issue(16'hC077);
        sb.push_back(f_dec(0)); sb.push_back(f_getb(3'd7));
        sb.push_back(f_comp(1, 2'b10, 2'b00, 1, 0)); sb.push_back(f_wreg(3'd3)); sb.push_back(f_idle());
        for (int i = 0; sb.size() > 0; i++) begin
            step(); bus.load_ir = 1'b0; bus.s = 1'b0;
            got = sample(); e = sb.pop_front(); vectors++;
            if (got !== e) begin miscompares++; $display("FAIL mov_reg[%0d]: got %h want %h", i, got, e); end
        end
    endtask

    task automatic test_cmp();
        // CMP R1,R0 : status load only, never a register write.
        issue(16'hA900);
        sb.push_back(f_dec(0)); sb.push_back(f_geta(3'd1)); sb.push_back(f_getb(3'd0));
        sb.push_back(f_comp(0, 2'b00, 2'b01, 0, 1)); sb.push_back(f_idle());
        for (int i = 0; sb.size() > 0; i++) begin
            step(); bus.load_ir = 1'b0; bus.s = 1'b0;
            got = sample(); e = sb.pop_front(); vectors++;
            if (got !== e) begin miscompares++; $display("FAIL cmp[%0d]: got %h want %h", i, got, e); end
        end
    endtask

    task automatic test_illegal();
        logic [15:0] words [3];
        words[0] = 16'hE000; words[1] = 16'hC800; words[2] = 16'h1234;
        for (int k = 0; k < 3; k++) begin
            issue(words[k]);
            sb.push_back(f_dec(1)); sb.push_back(f_idle());
            for (int i = 0; sb.size() > 0; i++) begin
                step(); bus.load_ir = 1'b0; bus.s = 1'b0;
                got = sample(); e = sb.pop_front(); vectors++;
                if (got !== e) begin miscompares++; $display("FAIL illegal_%h[%0d]: got %h want %h", words[k], i, got, e); end
            end
        end
    endtask

    task automatic test_busy_and_reset();
        // ADD with load_ir/s held high while busy, then reset during COMPUTE.
        issue(16'hA0A9);
        sb.push_back(f_dec(0)); sb.push_back(f_geta(3'd0)); sb.push_back(f_getb(3'd1));
        sb.push_back(f_comp(0, 2'b01, 2'b00, 1, 0));
        for (int i = 0; sb.size() > 0; i++) begin
            step();
            if (i == 0) begin bus.in = 16'hD7FF; bus.load_ir = 1'b1; bus.s = 1'b1; end
            got = sample(); e = sb.pop_front(); vectors++;
            if (got !== e) begin miscompares++; $display("FAIL busy[%0d]: got %h want %h", i, got, e); end
        end
        vectors++;
        if (bus.sximm8 !== 16'hFFA9) begin miscompares++; $display("FAIL busy_ir_kept: got sximm8=%h want FFA9", bus.sximm8); end
        bus.load_ir = 1'b0; bus.s = 1'b0;
        reset_n = 1'b0;
        step();
        got = sample(); e = f_idle(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL reset_mid: got %h want %h", got, e); end
        vectors++;
        if (bus.sximm8 !== 16'h0000) begin miscompares++; $display("FAIL reset_mid_ir: got sximm8=%h want 0000", bus.sximm8); end
        reset_n = 1'b1;
        step();
        got = sample(); e = f_idle(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL after_reset: got %h want %h", got, e); end
    endtask

    initial begin
        reset_n = 1'b0;
        bus.in = 16'h0000; bus.load_ir = 1'b0; bus.s = 1'b0;
        test_reset();
        test_mov_imm();
        test_sximm();
        test_alu();
        test_mov_reg();
        test_cmp();
        test_illegal();
        test_busy_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
